// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/AND/XOR/SHR/LDUI and
// WIDTH-iteration shift-add MUL / restoring DIVU, valid/ready on both sides.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       flags,
  output logic             busy
);
  localparam int          SHW  = $clog2(WIDTH);
  localparam int          HALF = WIDTH / 2;
  localparam int unsigned WU   = WIDTH;
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SHR, OP_LDUI, OP_MUL, OP_DIVU
  } op_t;

  state_t           state, nxt;
  op_t              op_in;
  logic             accept, multi, last;
  logic             op_div;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] sc_d, rmask, lmask;
  logic             sc_c, sc_v;
  int unsigned      kk, lsh;

  logic [WIDTH:0]   mul_sum, div_r, div_t;
  logic             div_ge;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign op_in     = op_t'(op);
  assign multi     = (op_in == OP_MUL) || (op_in == OP_DIVU);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == SHW'(WIDTH - 1));
  assign out_valid = (state == DONE);
  assign busy      = (state == ITER);

  assign add_w = {1'b0, s1} + {1'b0, s2};
  assign sub_w = {1'b0, s1} - {1'b0, s2};

  always_comb begin
    sc_d  = '0;
    sc_c  = 1'b0;
    sc_v  = 1'b0;
    kk    = 32'(s2[SHW-1:0]);
    lsh   = (WU - (kk % WU)) % WU;
    rmask = ~(ONES << kk);
    lmask = ~(ONES >> lsh);
    case (op_in)
      OP_ADD: begin
        sc_d = add_w[WIDTH-1:0];
        sc_c = add_w[WIDTH];
        sc_v = (s1[WIDTH-1] == s2[WIDTH-1]) && (add_w[WIDTH-1] != s1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_d = sub_w[WIDTH-1:0];
        sc_c = sub_w[WIDTH];
        sc_v = (s1[WIDTH-1] != s2[WIDTH-1]) && (sub_w[WIDTH-1] != s1[WIDTH-1]);
      end
      OP_AND: sc_d = s1 & s2;
      OP_XOR: sc_d = s1 ^ s2;
      OP_SHR: begin
        // Negative amount field means a left shift by its two's-complement magnitude
        if (s2[WIDTH-1]) begin
          sc_d = s1 << lsh;
          sc_c = |(s1 & lmask);
        end else begin
          sc_d = s1 >> kk;
          sc_c = |(s1 & rmask);
        end
      end
      OP_LDUI: sc_d = {s2[HALF-1:0], s1[HALF-1:0]};
      default: sc_d = '0;
    endcase
  end

  // One iteration: MUL keeps {hi,lo} as partial product / multiplier,
  // DIVU keeps hi as remainder and shifts quotient bits into lo.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_r   = {hi_q, lo_q[WIDTH-1]};
    div_t   = div_r - {1'b0, b_q};
    div_ge  = (div_r >= {1'b0, b_q});
    if (op_div) begin
      it_hi = div_ge ? div_t[WIDTH-1:0] : div_r[WIDTH-1:0];
      it_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = multi ? ITER : DONE;
      ITER: if (last) nxt = DONE;
      DONE: begin
        if (accept)         nxt = multi ? ITER : DONE;
        else if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_div <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt    <= '0;
      d      <= '0;
      flags  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt <= '0;
        if (multi) begin
          op_div <= (op_in == OP_DIVU);
          hi_q   <= '0;
          lo_q   <= (op_in == OP_MUL) ? s2 : s1;
          b_q    <= (op_in == OP_MUL) ? s1 : s2;
        end else begin
          d     <= sc_d;
          flags <= {(sc_d == '0), sc_c, sc_d[WIDTH-1], sc_v};
        end
      end else if (state == ITER) begin
        hi_q <= it_hi;
        lo_q <= it_lo;
        cnt  <= cnt + SHW'(1);
        if (last) begin
          d     <= it_lo;
          flags <= {(it_lo == '0), (op_div ? (b_q == '0) : (|it_hi)),
                    it_lo[WIDTH-1], 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed vectors, monitor pops on each transfer.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] s1 = '0, s2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] d;
  logic [3:0]   flags;
  logic         busy;

  typedef struct packed {logic [W-1:0] d; logic [3:0] f;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .s1(s1), .s2(s2), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: a result transfers at the next rising edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got d=%h flags=%h with empty scoreboard", d, flags);
      end else begin
        e = sb.pop_front();
        if (d !== e.d || flags !== e.f) begin
          failures++;
          $display("FAIL result: got d=%h flags=%h want d=%h flags=%h", d, flags, e.d, e.f);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic [3:0] ef);
    int n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; op = o; s1 = a; s2 = b;
    e.d = ed; e.f = ef;
    sb.push_back(e);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); s1 = W'($urandom); s2 = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic timed(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic [3:0] ef, input int lat);
    int edges, lowcnt;
    issue(o, a, b, ed, ef);
    check("busy_in_iter", 32'(busy), 32'd1);
    edges = 1; lowcnt = 0;
    while (!out_valid && edges < 100) begin
      if (!in_ready) lowcnt++;
      @(posedge clk); #1; edges++;
    end
    check("multi_latency", 32'(edges), 32'(lat));
    check("in_ready_low_cycles", 32'(lowcnt), 32'(lat - 1));
    drain();
  endtask

  initial begin
    int a1, a4;
    logic seen;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    issue(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'h3);
    check("single_cycle_valid", 32'(out_valid), 32'd1);
    issue(3'd1, 16'h0001, 16'h0002, 16'hFFFF, 4'h6);
    issue(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'hC);
    issue(3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'h1);
    issue(3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'h0);
    issue(3'd3, 16'hAAAA, 16'hAAAA, 16'h0000, 4'h8);
    issue(3'd4, 16'h8001, 16'h0001, 16'h4000, 4'h4);
    issue(3'd4, 16'h8001, 16'hFFFF, 16'h0002, 4'h4);
    issue(3'd4, 16'h1234, 16'h0000, 16'h1234, 4'h0);
    drain();

    timed(3'd6, 16'h0100, 16'h0100, 16'h0000, 4'hC, 17);
    timed(3'd6, 16'h00FF, 16'h0101, 16'hFFFF, 4'h2, 17);
    timed(3'd7, 16'd100, 16'd7, 16'd14, 4'h0, 17);
    timed(3'd7, 16'd5, 16'd0, 16'hFFFF, 4'h6, 17);

    // Backpressure: result must hold for three stalled cycles
    out_ready = 1'b0;
    issue(3'd5, 16'h0034, 16'h0012, 16'h1234, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_d", 32'(d), 32'h1234);
      check("hold_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Back-to-back ADDs: one acceptance (and one result) per edge
    issue(3'd0, 16'd1, 16'd1, 16'd2, 4'h0);
    a1 = acc_cyc;
    issue(3'd0, 16'h10, 16'h20, 16'h30, 4'h0);
    issue(3'd0, 16'd100, 16'd200, 16'd300, 4'h0);
    issue(3'd0, 16'h4000, 16'h4000, 16'h8000, 4'h3);
    a4 = acc_cyc;
    check("b2b_throughput", 32'(a4 - a1), 32'd3);
    drain();

    // Reset during the 5th ITER cycle of a MUL
    issue(3'd6, 16'h0003, 16'h0005, 16'h000F, 4'h0);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_d", 32'(d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_midrst", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check("no_stale_result", 32'(seen), 32'd0);
    issue(3'd0, 16'd2, 16'd3, 16'd5, 4'h0);
    check("post_rst_add_valid", 32'(out_valid), 32'd1);
    check("post_rst_add_d", 32'(d), 32'd5);
    drain();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL be even and >= 8.
REQ-002 Derived SHW = log2(WIDTH), shift-amount field width; HALF = WIDTH/2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  3  0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SHR, 5 LDUI, 6 MUL, 7 DIVU.
REQ-008 s1  input  WIDTH  first operand.
REQ-009 s2  input  WIDTH  second operand.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 d  output  WIDTH  registered result.
REQ-013 flags  output  4  registered {z,c,n,v}, z in MSB.
REQ-014 busy  output  1  high while in ITER.

Function
REQ-015 States: IDLE, ITER, DONE; acceptance = in_valid && in_ready at a rising edge.
REQ-016 in_ready SHALL be high in IDLE, high in DONE when out_ready is high, low in ITER.
REQ-017 op, s1, s2 SHALL be captured only at acceptance; later input changes SHALL NOT affect the result.
REQ-018 Ops 0-5 are single-cycle: acceptance -> DONE, out_valid high after exactly 1 edge.
REQ-019 MUL/DIVU: acceptance -> ITER for WIDTH edges, one iteration per edge -> DONE; out_valid high after exactly WIDTH+1 edges.
REQ-020 DONE: d, flags, out_valid SHALL hold stable until out_ready; on out_ready without new acceptance -> IDLE, out_valid low next edge.
REQ-021 Out_ready and a new acceptance in the same DONE cycle: old result retired, new request processed per REQ-018/019, no idle bubble for single-cycle ops.
REQ-022 ADD: d = (s1+s2) mod 2^WIDTH; c = carry out; v = signed overflow.
REQ-023 SUB: d = (s1-s2) mod 2^WIDTH; c = 1 iff s1 < s2 unsigned (borrow); v = signed overflow.
REQ-024 AND/XOR: bitwise; c = 0, v = 0.
REQ-025 SHR, k = s2[SHW-1:0]: s2[WIDTH-1]=0 -> logical right by k; s2[WIDTH-1]=1 -> left by (-k mod WIDTH); c = 1 iff any shifted-out bit is 1; v = 0.
REQ-026 LDUI: d = {s2[HALF-1:0], s1[HALF-1:0]}; c = 0, v = 0.
REQ-027 MUL: unsigned shift-add; d = low WIDTH bits of s1*s2; c = 1 iff high WIDTH bits nonzero; v = 0.
REQ-028 DIVU: unsigned restoring division; d = floor(s1/s2); v = 0; c = 0, except s2 = 0 -> d = all ones, c = 1.
REQ-029 All ops: z = (d == 0), n = d[WIDTH-1].
REQ-030 busy SHALL equal (state == ITER).

Reset
REQ-031 rst_n low SHALL immediately, asynchronously force IDLE, out_valid 0, d 0, flags 0, busy 0, iteration counter 0.
REQ-032 Reset during ITER or DONE SHALL discard the in-flight operation; no result SHALL appear after release.
REQ-033 in_ready SHALL be 1 in the first cycle after rst_n rises.

Verification (WIDTH=16)
REQ-034 ADD 0x7FFF, 0x0001 -> 1 edge later d=0x8000, z0 c0 n1 v1; SUB 0x0001, 0x0002 -> d=0xFFFF, c1 n1 v0.
REQ-035 SHR 0x8001, 0x0001 -> d=0x4000, c1; SHR 0x8001, 0xFFFF -> d=0x0002, c1; SHR 0x1234, 0x0000 -> d=0x1234, c0.
REQ-036 MUL 0x0100, 0x0100 -> in_ready low for 16 cycles, out_valid after exactly 17 edges, d=0x0000, z1 c1; MUL 0x00FF, 0x0101 -> d=0xFFFF, c0.
REQ-037 DIVU 100, 7 -> d=14, c0; DIVU 5, 0 -> d=0xFFFF, c1, n1.
REQ-038 Backpressure: LDUI 0x0034, 0x0012 with out_ready low 3 cycles -> d=0x1234 held, out_valid high throughout; back-to-back ADDs with out_ready high -> one result per cycle.
REQ-039 Reset mid-op: rst_n low during 5th ITER cycle of a MUL -> out_valid 0 and busy 0 immediately; after release, ADD 2, 3 -> d=5 after 1 edge.
